// File: rtl/asip_dmem_xbar_pkg.sv
// Shared encodings and default widths for the ASIP data-memory crossbar.
// Imported by the per-bank arbiter and the crossbar top.
package asip_dmem_xbar_pkg;

  localparam int MEM_W_DEF = 32;
  localparam int DMEMADDRW = 10;

  typedef enum logic {
    RW_WRITE = 1'b0,
    RW_READ  = 1'b1
  } rw_e;

  localparam logic EN_ACTIVE_B = 1'b0;
  localparam logic EN_IDLE_B   = 1'b1;

endpackage

// File: rtl/asip_bank_arb.sv
// Per-bank arbiter: resolves core/host hits on one bank and muxes the winner
// onto that bank's SRAM control, data and address pins.
module asip_bank_arb
  import asip_dmem_xbar_pkg::*;
#(
  parameter int MEM_W = MEM_W_DEF,
  parameter int BA_W  = 9
) (
  input  logic             core_hit,
  input  logic             host_hit,
  input  logic             host_pri,
  input  logic             core_rw,
  input  logic [BA_W-1:0]  core_baddr,
  input  logic [MEM_W-1:0] core_wdat,
  input  logic             host_rw,
  input  logic [BA_W-1:0]  host_baddr,
  input  logic [MEM_W-1:0] host_wdat,
  output logic             core_win,
  output logic             host_win,
  output logic             en_b,
  output logic             rw,
  output logic [BA_W-1:0]  addr,
  output logic [MEM_W-1:0] wdat
);

  // Core owns the bank on a conflict unless the host has been starved.
  assign core_win = core_hit & (~host_hit | ~host_pri);
  assign host_win = host_hit & (~core_hit |  host_pri);

  always_comb begin
    en_b = EN_IDLE_B;
    rw   = RW_READ;
    addr = '0;
    wdat = '0;
    if (host_win) begin
      en_b = EN_ACTIVE_B;
      rw   = host_rw;
      addr = host_baddr;
      wdat = host_wdat;
    end else if (core_win) begin
      en_b = EN_ACTIVE_B;
      rw   = core_rw;
      addr = core_baddr;
      wdat = core_wdat;
    end
  end

endmodule

// File: rtl/asip_dmem_xbar.sv
// Core/host to NBANK SRAM crossbar: combinational per-bank grant, host
// anti-starvation counter and one-cycle registered read-return routing.
module asip_dmem_xbar
  import asip_dmem_xbar_pkg::*;
#(
  parameter int MEM_W      = MEM_W_DEF,
  parameter int ADDR_W     = DMEMADDRW,
  parameter int NBANK      = 2,
  parameter int STARVE_MAX = 4,
  localparam int SEL_W     = $clog2(NBANK),
  localparam int BA_W      = ADDR_W - SEL_W
) (
  input  logic                   clk,
  input  logic                   reset_b,
  input  logic                   core_en_b,
  input  logic                   core_rw,
  input  logic [ADDR_W-1:0]      core_addr,
  input  logic [MEM_W-1:0]       core_wdat,
  output logic                   core_stall,
  output logic [MEM_W-1:0]       core_rdat,
  output logic                   core_rvalid,
  input  logic                   host_req,
  input  logic                   host_rw,
  input  logic [ADDR_W-1:0]      host_addr,
  input  logic [MEM_W-1:0]       host_wdat,
  output logic                   host_gnt,
  output logic [MEM_W-1:0]       host_rdat,
  output logic                   host_rvalid,
  output logic [NBANK-1:0]       bank_en_b,
  output logic [NBANK-1:0]       bank_rw,
  output logic [NBANK*BA_W-1:0]  bank_addr,
  output logic [NBANK*MEM_W-1:0] bank_wdat,
  input  logic [NBANK*MEM_W-1:0] bank_rdat
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic             core_req;
  logic             host_act;
  logic [SEL_W-1:0] core_sel;
  logic [SEL_W-1:0] host_sel;
  logic [BA_W-1:0]  core_baddr;
  logic [BA_W-1:0]  host_baddr;
  logic [NBANK-1:0] core_hit;
  logic [NBANK-1:0] host_hit;
  logic [NBANK-1:0] core_win;
  logic [NBANK-1:0] host_win;
  logic             core_gnt;
  logic             host_pri;
  logic [CNT_W-1:0] starve_cnt;
  logic [MEM_W-1:0] rdat_arr [NBANK];

  logic             core_vld_p1;
  logic             host_vld_p1;
  logic [SEL_W-1:0] core_bank_p1;
  logic [SEL_W-1:0] host_bank_p1;

  // Holding reset kills every request, so all banks idle while reset_b is low.
  assign core_req   = (core_en_b == EN_ACTIVE_B) && reset_b;
  assign host_act   = host_req && reset_b;
  assign core_sel   = core_addr[ADDR_W-1 -: SEL_W];
  assign host_sel   = host_addr[ADDR_W-1 -: SEL_W];
  assign core_baddr = core_addr[BA_W-1:0];
  assign host_baddr = host_addr[BA_W-1:0];

  generate
    if (STARVE_MAX == 0) begin : g_host_first
      assign host_pri = 1'b1;
    end else begin : g_host_starve
      assign host_pri = (starve_cnt >= CNT_W'(STARVE_MAX));
    end
  endgenerate

  // ---- p0: request decode and per-bank arbitration
  generate
    for (genvar gi = 0; gi < NBANK; gi++) begin : g_bank
      assign core_hit[gi] = core_req && (core_sel == SEL_W'(gi));
      assign host_hit[gi] = host_act && (host_sel == SEL_W'(gi));
      assign rdat_arr[gi] = bank_rdat[gi*MEM_W +: MEM_W];

      asip_bank_arb #(
        .MEM_W (MEM_W),
        .BA_W  (BA_W)
      ) u_arb (
        .core_hit   (core_hit[gi]),
        .host_hit   (host_hit[gi]),
        .host_pri   (host_pri),
        .core_rw    (core_rw),
        .core_baddr (core_baddr),
        .core_wdat  (core_wdat),
        .host_rw    (host_rw),
        .host_baddr (host_baddr),
        .host_wdat  (host_wdat),
        .core_win   (core_win[gi]),
        .host_win   (host_win[gi]),
        .en_b       (bank_en_b[gi]),
        .rw         (bank_rw[gi]),
        .addr       (bank_addr[gi*BA_W +: BA_W]),
        .wdat       (bank_wdat[gi*MEM_W +: MEM_W])
      );
    end
  endgenerate

  assign core_gnt   = |core_win;
  assign host_gnt   = |host_win;
  assign core_stall = core_req & ~core_gnt;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      starve_cnt <= '0;
    end else if (host_act && !host_gnt) begin
      if (starve_cnt != CNT_W'(STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

  // ---- p1: registered read-return routing
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      core_vld_p1 <= 1'b0;
      host_vld_p1 <= 1'b0;
    end else begin
      core_vld_p1 <= core_gnt && (core_rw == RW_READ);
      host_vld_p1 <= host_gnt && (host_rw == RW_READ);
    end
  end

  always_ff @(posedge clk) begin
    if (core_gnt) core_bank_p1 <= core_sel;
    if (host_gnt) host_bank_p1 <= host_sel;
  end

  assign core_rvalid = core_vld_p1;
  assign host_rvalid = host_vld_p1;
  assign core_rdat   = core_vld_p1 ? rdat_arr[core_bank_p1] : '0;
  assign host_rdat   = host_vld_p1 ? rdat_arr[host_bank_p1] : '0;

endmodule

// File: tb/tb_asip_dmem_xbar.sv
// Directed bench for asip_dmem_xbar: a 2-bank instance with SRAM models and
// a 4-bank host-first instance for the arbitration corner cases.
module tb_asip_dmem_xbar;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_b;

  // 2-bank instance, STARVE_MAX = 4
  logic        core_en_b, core_rw;
  logic [9:0]  core_addr;
  logic [31:0] core_wdat, core_rdat;
  logic        core_stall, core_rvalid;
  logic        host_req, host_rw;
  logic [9:0]  host_addr;
  logic [31:0] host_wdat, host_rdat;
  logic        host_gnt, host_rvalid;
  logic [1:0]  bank_en_b, bank_rw;
  logic [17:0] bank_addr;
  logic [63:0] bank_wdat, bank_rdat;

  // 4-bank instance, STARVE_MAX = 0
  logic         q_core_en_b, q_core_rw;
  logic [9:0]   q_core_addr;
  logic [31:0]  q_core_wdat, q_core_rdat;
  logic         q_core_stall, q_core_rvalid;
  logic         q_host_req, q_host_rw;
  logic [9:0]   q_host_addr;
  logic [31:0]  q_host_wdat, q_host_rdat;
  logic         q_host_gnt, q_host_rvalid;
  logic [3:0]   q_bank_en_b, q_bank_rw;
  logic [31:0]  q_bank_addr;
  logic [127:0] q_bank_wdat;
  logic [127:0] q_bank_rdat;

  int checks = 0;
  int errors = 0;

  asip_dmem_xbar #(.MEM_W(32), .ADDR_W(10), .NBANK(2), .STARVE_MAX(4)) dut2 (
    .clk(clk), .reset_b(reset_b),
    .core_en_b(core_en_b), .core_rw(core_rw), .core_addr(core_addr), .core_wdat(core_wdat),
    .core_stall(core_stall), .core_rdat(core_rdat), .core_rvalid(core_rvalid),
    .host_req(host_req), .host_rw(host_rw), .host_addr(host_addr), .host_wdat(host_wdat),
    .host_gnt(host_gnt), .host_rdat(host_rdat), .host_rvalid(host_rvalid),
    .bank_en_b(bank_en_b), .bank_rw(bank_rw), .bank_addr(bank_addr),
    .bank_wdat(bank_wdat), .bank_rdat(bank_rdat)
  );

  asip_dmem_xbar #(.MEM_W(32), .ADDR_W(10), .NBANK(4), .STARVE_MAX(0)) dut4 (
    .clk(clk), .reset_b(reset_b),
    .core_en_b(q_core_en_b), .core_rw(q_core_rw), .core_addr(q_core_addr), .core_wdat(q_core_wdat),
    .core_stall(q_core_stall), .core_rdat(q_core_rdat), .core_rvalid(q_core_rvalid),
    .host_req(q_host_req), .host_rw(q_host_rw), .host_addr(q_host_addr), .host_wdat(q_host_wdat),
    .host_gnt(q_host_gnt), .host_rdat(q_host_rdat), .host_rvalid(q_host_rvalid),
    .bank_en_b(q_bank_en_b), .bank_rw(q_bank_rw), .bank_addr(q_bank_addr),
    .bank_wdat(q_bank_wdat), .bank_rdat(q_bank_rdat)
  );

  assign q_bank_rdat = '0;

  // Synchronous single-port SRAM models for the 2-bank instance
  logic [31:0] mem [2][512];
  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (!bank_en_b[b]) begin
        if (bank_rw[b]) bank_rdat[b*32 +: 32] <= mem[b][bank_addr[b*9 +: 9]];
        else            mem[b][bank_addr[b*9 +: 9]] <= bank_wdat[b*32 +: 32];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with both requesters active on both instances
    reset_b   = 1'b0;
    core_en_b = 1'b0; core_rw = 1'b1; core_addr = 10'h005; core_wdat = '0;
    host_req  = 1'b1; host_rw = 1'b1; host_addr = 10'h005; host_wdat = '0;
    q_core_en_b = 1'b0; q_core_rw = 1'b1; q_core_addr = 10'h300; q_core_wdat = '0;
    q_host_req  = 1'b1; q_host_rw = 1'b1; q_host_addr = 10'h300; q_host_wdat = '0;
    repeat (2) tick();
    check("rst_bank_en_b", bank_en_b, 2'b11);
    check("rst_core_stall", core_stall, 1'b0);
    check("rst_host_gnt", host_gnt, 1'b0);
    check("rst_core_rvalid", core_rvalid, 1'b0);
    check("rst_host_rvalid", host_rvalid, 1'b0);
    check("rst_core_rdat", core_rdat, 32'h0);
    check("rst_bank_rw", bank_rw, 2'b11);
    check("rst_bank_addr", bank_addr, 18'h0);
    check("rst_bank_wdat", bank_wdat, 64'h0);
    check("rst_q_bank_en_b", q_bank_en_b, 4'hF);
    check("rst_q_host_gnt", q_host_gnt, 1'b0);

    core_en_b = 1'b1; host_req = 1'b0;
    q_core_en_b = 1'b1; q_host_req = 1'b0;
    reset_b = 1'b1;
    tick();

    // Core write then read of 0x005 (bank 0)
    core_en_b = 1'b0; core_rw = 1'b0; core_addr = 10'h005; core_wdat = 32'hA5A50001;
    #1;
    check("wr_bank_en_b", bank_en_b, 2'b10);
    check("wr_core_stall", core_stall, 1'b0);
    check("wr_bank_rw0", bank_rw[0], 1'b0);
    check("wr_bank_addr0", bank_addr[8:0], 9'h005);
    check("wr_bank_wdat0", bank_wdat[31:0], 32'hA5A50001);
    tick();
    core_rw = 1'b1;
    #1;
    check("rd_bank_en_b", bank_en_b, 2'b10);
    check("rd_core_stall", core_stall, 1'b0);
    check("wr_no_rvalid", core_rvalid, 1'b0);
    tick();
    check("rd_core_rvalid", core_rvalid, 1'b1);
    check("rd_core_rdat", core_rdat, 32'hA5A50001);

    // Core read bank 0 and host write bank 1 in the same cycle
    host_req = 1'b1; host_rw = 1'b0; host_addr = 10'h205; host_wdat = 32'h12345678;
    #1;
    check("dual_bank_en_b", bank_en_b, 2'b00);
    check("dual_core_stall", core_stall, 1'b0);
    check("dual_host_gnt", host_gnt, 1'b1);
    check("dual_bank_addr1", bank_addr[17:9], 9'h005);
    check("dual_bank_wdat1", bank_wdat[63:32], 32'h12345678);
    tick();
    core_en_b = 1'b1; host_rw = 1'b1;
    #1;
    check("dual_core_rvalid", core_rvalid, 1'b1);
    check("dual_core_rdat", core_rdat, 32'hA5A50001);
    check("dual_host_wr_no_rvalid", host_rvalid, 1'b0);
    check("host_rd_gnt", host_gnt, 1'b1);
    tick();
    host_req = 1'b0;
    #1;
    check("host_rd_rvalid", host_rvalid, 1'b1);
    check("host_rd_rdat", host_rdat, 32'h12345678);
    check("idle_core_rdat", core_rdat, 32'h0);

    // Host starvation: core streams bank-0 reads, host wants 0x010
    core_en_b = 1'b0; core_rw = 1'b1; core_addr = 10'h005;
    host_req = 1'b1; host_rw = 1'b1; host_addr = 10'h010;
    for (int c = 1; c <= 5; c++) begin
      #1;
      check($sformatf("starve_gnt_c%0d", c), host_gnt, (c == 5));
      check($sformatf("starve_stall_c%0d", c), core_stall, (c == 5));
      check($sformatf("starve_core_rvalid_c%0d", c), core_rvalid, (c >= 2));
      tick();
    end
    host_req = 1'b0;
    #1;
    check("starve_host_rvalid", host_rvalid, 1'b1);
    check("starve_core_bubble", core_rvalid, 1'b0);
    check("starve_core_regrant", core_stall, 1'b0);
    check("starve_core_en_b", bank_en_b, 2'b10);
    tick();
    core_en_b = 1'b1;
    #1;
    check("starve_core_rvalid_after", core_rvalid, 1'b1);
    tick();

    // Reset pulsed while a granted core read is in flight
    core_en_b = 1'b0; core_rw = 1'b1; core_addr = 10'h005;
    #1;
    check("rst_mid_pre_stall", core_stall, 1'b0);
    #2;
    reset_b = 1'b0;
    #1;
    check("rst_mid_bank_en_b", bank_en_b, 2'b11);
    check("rst_mid_core_stall", core_stall, 1'b0);
    check("rst_mid_core_rvalid", core_rvalid, 1'b0);
    tick();
    check("rst_mid_rvalid_edge", core_rvalid, 1'b0);
    check("rst_mid_core_rdat", core_rdat, 32'h0);
    core_en_b = 1'b1;
    reset_b = 1'b1;
    tick();
    check("rst_mid_rvalid_after", core_rvalid, 1'b0);
    check("rst_mid_host_rvalid", host_rvalid, 1'b0);

    // 4 banks, host always wins a conflict
    q_core_en_b = 1'b0; q_core_rw = 1'b1; q_core_addr = 10'h300;
    q_host_req = 1'b1; q_host_rw = 1'b0; q_host_addr = 10'h300; q_host_wdat = 32'hDEADBEEF;
    #1;
    check("q_conflict_host_gnt", q_host_gnt, 1'b1);
    check("q_conflict_core_stall", q_core_stall, 1'b1);
    check("q_conflict_bank_en_b", q_bank_en_b, 4'b0111);
    check("q_conflict_bank_wdat3", q_bank_wdat[127:96], 32'hDEADBEEF);
    check("q_conflict_bank_rw3", q_bank_rw[3], 1'b0);
    q_core_addr = 10'h100;
    #1;
    check("q_split_bank_en_b", q_bank_en_b, 4'b0101);
    check("q_split_core_stall", q_core_stall, 1'b0);
    check("q_split_host_gnt", q_host_gnt, 1'b1);
    tick();
    q_core_en_b = 1'b1; q_host_req = 1'b0;
    #1;
    check("q_split_core_rvalid", q_core_rvalid, 1'b1);
    check("q_split_core_rdat", q_core_rdat, 32'h0);
    check("q_host_wr_no_rvalid", q_host_rvalid, 1'b0);
    check("q_host_rdat_idle", q_host_rdat, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
